// File: rtl/hazard_unit.sv
// Hazard detection and pipeline sequencing for the 5-stage MIPS core: classifies each
// cycle (freeze / redirect / load-use stall / run), drives buffer controls and forwarding selects.
module hazard_unit #(
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] d_rs_a,
  input  logic [AW-1:0] d_rt_a,
  input  logic          d_uses_rs,
  input  logic          d_uses_rt,
  input  logic [AW-1:0] dx_wr_a,
  input  logic          dx_reg_write,
  input  logic          dx_mem_read,
  input  logic [AW-1:0] xm_wr_a,
  input  logic          xm_reg_write,
  input  logic          m_branch_taken,
  input  logic          m_jmp,
  input  logic          mem_busy,
  output logic          stall,
  output logic          dx_bubble,
  output logic          flush_fd,
  output logic          flush_dx,
  output logic          flush_xm,
  output logic          freeze,
  output logic          fwdX_rs,
  output logic          fwdX_rt,
  output logic          fwdM_rs,
  output logic          fwdM_rt,
  output logic          wb_valid,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt,
  output logic [CW-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    CLS_RUN,
    CLS_STALL,
    CLS_REDIRECT,
    CLS_FREEZE
  } cycle_class_e;

  logic v_fd_q, v_dx_q, v_xm_q, v_mw_q;
  logic v_fd_d, v_dx_d, v_xm_d, v_mw_d;

  logic [CW-1:0] stall_cnt_q, flush_cnt_q, retire_cnt_q;
  logic [CW-1:0] stall_cnt_d, flush_cnt_d, retire_cnt_d;

  logic         redirect;
  logic         load_use;
  logic         x_hit_rs, x_hit_rt, m_hit_rs, m_hit_rt;
  cycle_class_e cls;

  // Register $0 is hardwired, so a write to it is never a real producer.
  function automatic logic producer_match(input logic          valid,
                                          input logic          writes,
                                          input logic [AW-1:0] dst,
                                          input logic [AW-1:0] src);
    return valid & writes & (dst == src) & (src != '0);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt, input logic en);
    return (en && (cnt != '1)) ? cnt + CW'(1) : cnt;
  endfunction

  assign x_hit_rs = producer_match(v_dx_q, dx_reg_write, dx_wr_a, d_rs_a);
  assign x_hit_rt = producer_match(v_dx_q, dx_reg_write, dx_wr_a, d_rt_a);
  assign m_hit_rs = producer_match(v_xm_q, xm_reg_write, xm_wr_a, d_rs_a);
  assign m_hit_rt = producer_match(v_xm_q, xm_reg_write, xm_wr_a, d_rt_a);

  assign redirect = v_xm_q & (m_branch_taken | m_jmp);
  assign load_use = v_fd_q & v_dx_q & dx_mem_read &
                    ((d_uses_rs & (dx_wr_a == d_rs_a) & (d_rs_a != '0)) |
                     (d_uses_rt & (dx_wr_a == d_rt_a) & (d_rt_a != '0)));

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    cls       = CLS_RUN;
    stall     = 1'b0;
    dx_bubble = 1'b0;
    flush_fd  = 1'b0;
    flush_dx  = 1'b0;
    flush_xm  = 1'b0;
    freeze    = 1'b0;
    if (mem_busy) begin
      cls    = CLS_FREEZE;
      freeze = 1'b1;
      stall  = 1'b1;
    end else if (redirect) begin
      cls      = CLS_REDIRECT;
      flush_fd = 1'b1;
      flush_dx = 1'b1;
      flush_xm = 1'b1;
    end else if (load_use) begin
      cls       = CLS_STALL;
      stall     = 1'b1;
      dx_bubble = 1'b1;
    end
  end

  // A load in X cannot forward; its consumer is stalled and picks the value up from M.
  always_comb begin
    fwdX_rs = d_uses_rs & x_hit_rs & ~dx_mem_read;
    fwdX_rt = d_uses_rt & x_hit_rt & ~dx_mem_read;
    fwdM_rs = d_uses_rs & m_hit_rs & ~fwdX_rs;
    fwdM_rt = d_uses_rt & m_hit_rt & ~fwdX_rt;
  end

  always_comb begin
    v_fd_d = v_fd_q;
    v_dx_d = v_dx_q;
    v_xm_d = v_xm_q;
    v_mw_d = v_mw_q;
    unique case (cls)
      CLS_FREEZE: ;
      CLS_REDIRECT: begin
        v_fd_d = 1'b0;
        v_dx_d = 1'b0;
        v_xm_d = 1'b0;
        v_mw_d = v_xm_q;
      end
      CLS_STALL: begin
        v_dx_d = 1'b0;
        v_xm_d = v_dx_q;
        v_mw_d = v_xm_q;
      end
      default: begin
        v_fd_d = 1'b1;
        v_dx_d = v_fd_q;
        v_xm_d = v_dx_q;
        v_mw_d = v_xm_q;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d  = sat_inc(stall_cnt_q, stall);
    flush_cnt_d  = sat_inc(flush_cnt_q, cls == CLS_REDIRECT);
    retire_cnt_d = sat_inc(retire_cnt_q, (cls != CLS_FREEZE) & v_mw_q);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_fd_q       <= 1'b0;
      v_dx_q       <= 1'b0;
      v_xm_q       <= 1'b0;
      v_mw_q       <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      v_fd_q       <= v_fd_d;
      v_dx_q       <= v_dx_d;
      v_xm_q       <= v_xm_d;
      v_mw_q       <= v_mw_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign wb_valid   = v_mw_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a stage-shift reference model compared every cycle,
// plus directed scenarios with literal expectations; a CW=2 copy checks counter saturation.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] d_rs_a, d_rt_a, dx_wr_a, xm_wr_a;
  logic       d_uses_rs, d_uses_rt, dx_reg_write, dx_mem_read, xm_reg_write;
  logic       m_branch_taken, m_jmp, mem_busy;

  logic        stall, dx_bubble, flush_fd, flush_dx, flush_xm, freeze;
  logic        fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt, wb_valid;
  logic [15:0] stall_cnt, flush_cnt, retire_cnt;

  logic       s_stall, s_dx_bubble, s_flush_fd, s_flush_dx, s_flush_xm, s_freeze;
  logic       s_fwdX_rs, s_fwdX_rt, s_fwdM_rs, s_fwdM_rt, s_wb_valid;
  logic [1:0] s_stall_cnt, s_flush_cnt, s_retire_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_unit #(.AW(5), .CW(16)) dut (
    .clk(clk), .rst(rst), .d_rs_a(d_rs_a), .d_rt_a(d_rt_a),
    .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .dx_wr_a(dx_wr_a),
    .dx_reg_write(dx_reg_write), .dx_mem_read(dx_mem_read), .xm_wr_a(xm_wr_a),
    .xm_reg_write(xm_reg_write), .m_branch_taken(m_branch_taken), .m_jmp(m_jmp),
    .mem_busy(mem_busy), .stall(stall), .dx_bubble(dx_bubble), .flush_fd(flush_fd),
    .flush_dx(flush_dx), .flush_xm(flush_xm), .freeze(freeze), .fwdX_rs(fwdX_rs),
    .fwdX_rt(fwdX_rt), .fwdM_rs(fwdM_rs), .fwdM_rt(fwdM_rt), .wb_valid(wb_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
  );

  hazard_unit #(.AW(5), .CW(2)) dut_sat (
    .clk(clk), .rst(rst), .d_rs_a(d_rs_a), .d_rt_a(d_rt_a),
    .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .dx_wr_a(dx_wr_a),
    .dx_reg_write(dx_reg_write), .dx_mem_read(dx_mem_read), .xm_wr_a(xm_wr_a),
    .xm_reg_write(xm_reg_write), .m_branch_taken(m_branch_taken), .m_jmp(m_jmp),
    .mem_busy(mem_busy), .stall(s_stall), .dx_bubble(s_dx_bubble), .flush_fd(s_flush_fd),
    .flush_dx(s_flush_dx), .flush_xm(s_flush_xm), .freeze(s_freeze), .fwdX_rs(s_fwdX_rs),
    .fwdX_rt(s_fwdX_rt), .fwdM_rs(s_fwdM_rs), .fwdM_rt(s_fwdM_rt), .wb_valid(s_wb_valid),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .retire_cnt(s_retire_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // mv bit 0..3 = instruction valid in FD, DX, XM, MW.
  bit [3:0] mv = '0;
  int m_stall = 0, m_flush = 0, m_retire = 0;

  function automatic bit hit(bit valid, bit writes, logic [4:0] dst, logic [4:0] src);
    return valid && writes && dst == src && src != 0;
  endfunction

  function automatic bit m_redirect();
    return mv[2] && (m_branch_taken || m_jmp);
  endfunction

  function automatic bit m_load_use();
    return mv[0] && mv[1] && dx_mem_read &&
           ((d_uses_rs && dx_wr_a == d_rs_a && d_rs_a != 0) ||
            (d_uses_rt && dx_wr_a == d_rt_a && d_rt_a != 0));
  endfunction

  function automatic int sat16(int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic int sat2(int v);
    return (v > 3) ? 3 : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mv       <= '0;
      m_stall  <= 0;
      m_flush  <= 0;
      m_retire <= 0;
    end else if (mem_busy) begin
      m_stall <= m_stall + 1;
    end else begin
      m_retire <= m_retire + int'(mv[3]);
      if (m_redirect()) begin
        mv      <= {mv[2], 3'b000};
        m_flush <= m_flush + 1;
      end else if (m_load_use()) begin
        mv      <= {mv[2:1], 1'b0, mv[0]};
        m_stall <= m_stall + 1;
      end else begin
        mv <= {mv[2:0], 1'b1};
      end
    end
  end

  always @(negedge clk) begin
    bit e_red, e_lu, e_fxs, e_fxt, e_fms, e_fmt;
    e_red = !mem_busy && m_redirect();
    e_lu  = !mem_busy && !m_redirect() && m_load_use();
    e_fxs = d_uses_rs && hit(mv[1], dx_reg_write, dx_wr_a, d_rs_a) && !dx_mem_read;
    e_fxt = d_uses_rt && hit(mv[1], dx_reg_write, dx_wr_a, d_rt_a) && !dx_mem_read;
    e_fms = d_uses_rs && hit(mv[2], xm_reg_write, xm_wr_a, d_rs_a) && !e_fxs;
    e_fmt = d_uses_rt && hit(mv[2], xm_reg_write, xm_wr_a, d_rt_a) && !e_fxt;
    check("cyc_freeze",   32'(freeze),    32'(mem_busy));
    check("cyc_stall",    32'(stall),     32'(mem_busy || e_lu));
    check("cyc_bubble",   32'(dx_bubble), 32'(e_lu));
    check("cyc_flush_fd", 32'(flush_fd),  32'(e_red));
    check("cyc_flush_dx", 32'(flush_dx),  32'(e_red));
    check("cyc_flush_xm", 32'(flush_xm),  32'(e_red));
    check("cyc_fwdX_rs",  32'(fwdX_rs),   32'(e_fxs));
    check("cyc_fwdX_rt",  32'(fwdX_rt),   32'(e_fxt));
    check("cyc_fwdM_rs",  32'(fwdM_rs),   32'(e_fms));
    check("cyc_fwdM_rt",  32'(fwdM_rt),   32'(e_fmt));
    check("cyc_wb_valid", 32'(wb_valid),  32'(mv[3]));
    check("cyc_stall_cnt",  32'(stall_cnt),  sat16(m_stall));
    check("cyc_flush_cnt",  32'(flush_cnt),  sat16(m_flush));
    check("cyc_retire_cnt", 32'(retire_cnt), sat16(m_retire));
    check("cyc_sat_stall_cnt",  32'(s_stall_cnt),  sat2(m_stall));
    check("cyc_sat_flush_cnt",  32'(s_flush_cnt),  sat2(m_flush));
    check("cyc_sat_retire_cnt", 32'(s_retire_cnt), sat2(m_retire));
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_inputs();
    d_rs_a = '0; d_rt_a = '0; d_uses_rs = 1'b0; d_uses_rt = 1'b0;
    dx_wr_a = '0; dx_reg_write = 1'b0; dx_mem_read = 1'b0;
    xm_wr_a = '0; xm_reg_write = 1'b0;
    m_branch_taken = 1'b0; m_jmp = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load_use();
    dx_mem_read = 1'b1; dx_reg_write = 1'b1; dx_wr_a = 5'd2;
    d_uses_rs = 1'b1; d_rs_a = 5'd2;
  endtask

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_stall", 32'(stall), 0);
    check("reset_wb_valid", 32'(wb_valid), 0);
    check("reset_stall_cnt", 32'(stall_cnt), 0);

    // Fill: FD valid after edge 1, MW after edge 4, first retire on edge 5.
    for (int e = 1; e <= 5; e++) begin
      cycle();
      #1;
      if (e == 3) check("fill_wb_edge3", 32'(wb_valid), 0);
      if (e == 4) begin
        check("fill_wb_edge4", 32'(wb_valid), 1);
        check("fill_retire_edge4", 32'(retire_cnt), 0);
      end
      if (e == 5) begin
        check("fill_retire_edge5", 32'(retire_cnt), 1);
        check("fill_no_stall", 32'(stall), 0);
      end
    end

    // Load-use on rs=$2: one stall, then the load in M forwards.
    drive_load_use();
    #1;
    check("lu_stall", 32'(stall), 1);
    check("lu_bubble", 32'(dx_bubble), 1);
    cycle();
    dx_mem_read = 1'b0; dx_reg_write = 1'b0;
    xm_wr_a = 5'd2; xm_reg_write = 1'b1;
    #1;
    check("lu_after_fwdM_rs", 32'(fwdM_rs), 1);
    check("lu_after_stall", 32'(stall), 0);
    check("lu_stall_cnt", 32'(stall_cnt), 1);
    cycle();
    clear_inputs();
    cycle();

    // Two producers of $5: X (youngest) wins; $0 never forwards.
    dx_reg_write = 1'b1; dx_wr_a = 5'd5;
    xm_reg_write = 1'b1; xm_wr_a = 5'd5;
    d_uses_rt = 1'b1; d_rt_a = 5'd5;
    #1;
    check("dbl_fwdX_rt", 32'(fwdX_rt), 1);
    check("dbl_fwdM_rt", 32'(fwdM_rt), 0);
    d_rt_a = 5'd0;
    #1;
    check("r0_fwdX_rt", 32'(fwdX_rt), 0);
    check("r0_fwdM_rt", 32'(fwdM_rt), 0);
    cycle();

    // Taken branch in M beats a load-use in D.
    clear_inputs();
    drive_load_use();
    m_branch_taken = 1'b1;
    #1;
    check("br_flush_fd", 32'(flush_fd), 1);
    check("br_flush_dx", 32'(flush_dx), 1);
    check("br_flush_xm", 32'(flush_xm), 1);
    check("br_stall", 32'(stall), 0);
    check("br_bubble", 32'(dx_bubble), 0);
    cycle();
    clear_inputs();
    m_jmp = 1'b1;
    #1;
    check("jmp_ignored_flush_xm", 32'(flush_xm), 0);
    check("jmp_ignored_flush_fd", 32'(flush_fd), 0);
    check("br_flush_cnt", 32'(flush_cnt), 1);
    cycle();
    m_jmp = 1'b0;
    cycle();

    // Three frozen cycles over a pending load-use, then the load-use stall itself.
    drive_load_use();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("frz_freeze", 32'(freeze), 1);
      check("frz_stall", 32'(stall), 1);
      check("frz_bubble", 32'(dx_bubble), 0);
      cycle();
    end
    mem_busy = 1'b0;
    #1;
    check("frz_then_freeze", 32'(freeze), 0);
    check("frz_then_stall", 32'(stall), 1);
    check("frz_then_bubble", 32'(dx_bubble), 1);
    cycle();
    #1;
    // One stall from the earlier load-use plus three freezes and one stall here.
    check("frz_stall_cnt", 32'(stall_cnt), 5);
    check("sat_stall_cnt_cw2", 32'(s_stall_cnt), 3);

    // Asynchronous reset in the middle of a stall.
    cycle();
    #1;
    check("pre_rst_stall", 32'(stall), 1);
    rst = 1'b1;
    #1;
    check("rst_stall", 32'(stall), 0);
    check("rst_bubble", 32'(dx_bubble), 0);
    check("rst_fwdM_rs", 32'(fwdM_rs), 0);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_flush_cnt", 32'(flush_cnt), 0);
    check("rst_retire_cnt", 32'(retire_cnt), 0);
    check("rst_sat_stall_cnt", 32'(s_stall_cnt), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    clear_inputs();
    cycle();
    cycle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
